// File: rtl/divu_seq_if.sv
// Handshake and operand/result bundle for the sequential 8/4 unsigned divider.
// The controller drives start/A/B; the divider returns Q/R/dz with busy/done status.
interface divu_seq_if;
  logic       start;
  logic [7:0] A;
  logic [3:0] B;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       dz;

  modport master (output start, A, B, input Q, R, busy, done, dz);
  modport slave  (input start, A, B, output Q, R, busy, done, dz);
endinterface

// File: rtl/divu_seq.sv
// Restoring shift-subtract divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per clock, with a start/busy/done handshake and a divide-by-zero flag.
module divu_seq (
  input logic       clk,
  input logic       rst_n,
  divu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg;
  logic [7:0] dvd_reg;
  logic [3:0] dvs_reg;
  logic [4:0] rem_reg;
  logic [7:0] quo_reg;
  logic [2:0] cnt_reg;
  logic [7:0] q_reg;
  logic [3:0] r_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       dz_reg;

  logic [4:0] p_next;
  logic       qbit_next;
  logic [4:0] rem_next;
  logic [7:0] quo_next;

  // p can reach 2*B-1 (<= 29), so the trial remainder needs five bits
  assign p_next    = (rem_reg << 1) | {4'b0000, dvd_reg[7]};
  assign qbit_next = (p_next >= {1'b0, dvs_reg});
  assign rem_next  = qbit_next ? (p_next - {1'b0, dvs_reg}) : p_next;
  assign quo_next  = {quo_reg[6:0], qbit_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      cnt_reg   <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          if (bus.start) begin
            if (bus.B != 4'd0) begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
              dvd_reg   <= bus.A;
              dvs_reg   <= bus.B;
              rem_reg   <= '0;
              quo_reg   <= '0;
              cnt_reg   <= '0;
            end else begin
              // Zero divisor skips the iterations and reports saturated results
              state_reg <= DONE;
              done_reg  <= 1'b1;
              q_reg     <= 8'hFF;
              r_reg     <= 4'hF;
              dz_reg    <= 1'b1;
            end
          end
        end

        RUN: begin
          dvd_reg <= dvd_reg << 1;
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            q_reg     <= quo_next;
            r_reg     <= rem_next[3:0];
            dz_reg    <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.dz   = dz_reg;

endmodule

// File: tb/tb_divu_seq.sv
// Directed and randomized bench for divu_seq; expected results come from plain
// integer division and the handshake timing rules.
module tb_divu_seq;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;
  logic [12:0] prev;

  divu_seq_if bus ();

  divu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({bus.Q, bus.R, bus.busy, bus.done, bus.dz}), 32'd0);
  endtask

  // One operation with start pulsed; optional stray start at RUN cycle inject_at
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int inject_at);
    int n;
    logic [7:0] eq;
    logic [3:0] er;
    logic edz;
    if (b == 4'd0) begin
      eq = 8'hFF; er = 4'hF; edz = 1'b1;
    end else begin
      eq = 8'(int'(a) / int'(b)); er = 4'(int'(a) % int'(b)); edz = 1'b0;
    end
    bus.start = 1'b1; bus.A = a; bus.B = b;
    cycle();
    bus.start = 1'b0; bus.A = 8'($urandom); bus.B = 4'($urandom);
    n = 0;
    while (!bus.done && n < 20) begin
      check("busy_run", 32'(bus.busy), 32'd1);
      check("hold_run", 32'({bus.Q, bus.R, bus.dz}), 32'(prev));
      if (n == inject_at) begin
        bus.start = 1'b1; bus.A = 8'($urandom); bus.B = 4'($urandom_range(15, 1));
      end else begin
        bus.start = 1'b0;
      end
      cycle();
      n++;
    end
    bus.start = 1'b0;
    check("latency", 32'(n), (b == 4'd0) ? 32'd0 : 32'd8);
    check("done", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("Q", 32'(bus.Q), 32'(eq));
    check("R", 32'(bus.R), 32'(er));
    check("dz", 32'(bus.dz), 32'(edz));
    $display("op A=%0d B=%0d -> Q=%0d R=%0d dz=%0d cycles=%0d", a, b, bus.Q, bus.R, bus.dz, n);
    prev = {eq, er, edz};
    cycle();
    check("done_pulse", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int a;
    int b;
    chk_cnt  = 0;
    pass_cnt = 0;
    prev     = '0;

    // Reset held with random inputs
    rst_n = 1'b0;
    bus.start = 1'b1; bus.A = 8'($urandom); bus.B = 4'($urandom);
    repeat (3) begin
      cycle();
      bus.start = 1'($urandom); bus.A = 8'($urandom); bus.B = 4'($urandom);
      check_zero("reset_hold");
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (6) cycle();
    check_zero("idle_after_reset");
    $display("reset released, outputs idle");

    // Basic and corner divides
    run_op(8'd200, 4'd7, -1);
    run_op(8'd255, 4'd1, -1);
    run_op(8'd0, 4'd15, -1);
    run_op(8'd14, 4'd15, -1);
    run_op(8'd255, 4'd15, -1);

    // Divide by zero then a normal divide
    run_op(8'd13, 4'd0, -1);
    run_op(8'd9, 4'd3, -1);

    // Stray start mid-RUN is ignored
    run_op(8'd200, 4'd7, 3);

    // Consecutive divide-by-zero starts give back-to-back done pulses
    bus.start = 1'b1; bus.A = 8'd77; bus.B = 4'd0;
    cycle();
    check("dz0_done1", 32'({bus.done, bus.dz, bus.Q, bus.R}), 32'({2'b11, 8'hFF, 4'hF}));
    cycle();
    check("dz0_done2", 32'({bus.done, bus.dz, bus.busy}), 32'b110);
    bus.start = 1'b0;
    cycle();
    check("dz0_end", 32'(bus.done), 32'd0);
    $display("op A=77 B=0 twice -> done pulses back-to-back");
    prev = {8'hFF, 4'hF, 1'b1};

    // Reset asserted after iteration 4 aborts the divide
    bus.start = 1'b1; bus.A = 8'd200; bus.B = 4'd7;
    cycle();
    bus.start = 1'b0;
    repeat (4) cycle();
    check("busy_pre_abort", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("abort_async");
    cycle();
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      cycle();
      if (bus.done) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    check_zero("abort_outputs");
    $display("abort mid-run -> done pulses=%0d", n);
    prev = '0;

    // Exhaustive back-to-back sweep with start held high
    bus.start = 1'b1; bus.A = 8'd0; bus.B = 4'd1;
    cycle();
    for (int i = 0; i < 3840; i++) begin
      a = i % 256;
      b = i / 256 + 1;
      n = 0;
      while (!bus.done && n < 20) begin
        check("x_busy", 32'(bus.busy), 32'd1);
        check("x_hold", 32'({bus.Q, bus.R, bus.dz}), 32'(prev));
        bus.A = 8'($urandom); bus.B = 4'($urandom);
        cycle();
        n++;
      end
      check("x_latency", 32'(n), 32'd8);
      check("x_ident", 32'(int'(bus.Q) * b + int'(bus.R)), 32'(a));
      check("x_r_lt_b", 32'(int'(bus.R) < b), 32'd1);
      check("x_quot", 32'(bus.Q), 32'(a / b));
      check("x_dz", 32'(bus.dz), 32'd0);
      check("x_busy_done", 32'(bus.busy), 32'd0);
      $display("op A=%0d B=%0d -> Q=%0d R=%0d back-to-back", a, b, bus.Q, bus.R);
      prev = {bus.Q, bus.R, bus.dz};
      if (i < 3839) begin
        bus.A = 8'((i + 1) % 256);
        bus.B = 4'((i + 1) / 256 + 1);
      end else begin
        bus.start = 1'b0;
      end
      cycle();
      check("x_done_pulse", 32'(bus.done), 32'd0);
    end
    check("x_final_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
